// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Results satisfy q*b + r == a; a zero divisor yields q = all ones, r = a, div_zero = 1.
module div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CNT_W-1:0] cnt;

  logic             load_en;
  logic             step_en;
  logic             busy_nxt;
  logic             done_nxt;
  logic [WIDTH:0]   step_res;

  // One restoring step: returns {quotient bit, next partial remainder}.
  // A non-negative trial always fits in WIDTH bits because it is below the divisor.
  function automatic logic [WIDTH:0] restore_step(
    input logic [WIDTH-1:0] rem_in,
    input logic             msb_in,
    input logic [WIDTH-1:0] dsr_in
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {rem_in, msb_in};
    trial   = shifted - {1'b0, dsr_in};
    if (!trial[WIDTH]) begin
      restore_step = {1'b1, trial[WIDTH-1:0]};
    end else begin
      restore_step = {1'b0, shifted[WIDTH-1:0]};
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode; the visible outputs are registered one cycle behind the state.
  always_comb begin
    load_en  = 1'b0;
    step_en  = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE: load_en = start;
      CALC: begin
        step_en  = 1'b1;
        busy_nxt = 1'b1;
      end
      DONE: begin
        load_en  = start;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  assign step_res = restore_step(rem, dividend[WIDTH-1], divisor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
    end else if (load_en) begin
      dividend <= a;
      divisor  <= b;
      rem      <= '0;
      quo      <= '0;
      cnt      <= CNT_LOAD;
    end else if (step_en) begin
      dividend <= {dividend[WIDTH-2:0], 1'b0};
      rem      <= step_res[WIDTH-1:0];
      quo      <= {quo[WIDTH-2:0], step_res[WIDTH]};
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

  // Result registers move only when a division completes; a new start leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (done_nxt) begin
        q        <= quo;
        r        <= rem;
        div_zero <= (divisor == '0);
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (WIDTH=8): latency, handshake, divide-by-zero,
// ignored mid-flight starts, asynchronous reset abort and a sampled operand sweep.
module tb_div_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
  logic       div_zero;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one start, then watch 11 cycles: done must land 9 edges after acceptance.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int done_at;
    int busy_cnt;
    int done_cnt;
    logic [7:0] cq;
    logic [7:0] cr;
    logic cz;
    done_at  = -1;
    busy_cnt = 0;
    done_cnt = 0;
    cq = 8'hxx;
    cr = 8'hxx;
    cz = 1'bx;
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          cq = q;
          cr = r;
          cz = div_zero;
        end
      end
    end
    chk({tag, "_latency"}, done_at, 9);
    chk({tag, "_busy_cycles"}, busy_cnt, 8);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_q"}, cq, eq);
    chk({tag, "_r"}, cr, er);
    chk({tag, "_div_zero"}, cz, ez);
  endtask

  initial begin
    int done_cnt;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] eq;
    logic [7:0] er;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_div_zero", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    chk("hold_q", q, 28);
    chk("hold_r", r, 4);
    run_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run_op("d5_10", 8'd5, 8'd10, 8'd0, 8'd5, 1'b0);
    run_op("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
    run_op("d77_0", 8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
    run_op("d100_10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0);

    // start held high: operands changed mid-CALC are ignored until the DONE-cycle accept
    @(negedge clk);
    a = 8'd200;
    b = 8'd7;
    start = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      @(negedge clk);
      if (k == 3) begin
        a = 8'd9;
        b = 8'd3;
      end
      if (k == 9) begin
        chk("b2b_done1", done, 1);
        chk("b2b_busy_in_done", busy, 0);
        chk("b2b_q1", q, 28);
        chk("b2b_r1", r, 4);
        start = 1'b0;
      end
      if (k == 10) chk("b2b_busy_restart", busy, 1);
      if (k == 12) chk("b2b_q_held", q, 28);
      if (k == 17) chk("b2b_no_early_done", done, 0);
      if (k == 18) begin
        chk("b2b_done2", done, 1);
        chk("b2b_q2", q, 3);
        chk("b2b_r2", r, 0);
      end
      if (k == 19) chk("b2b_done2_pulse", done, 0);
    end

    // asynchronous reset in the middle of CALC aborts the division
    @(negedge clk);
    a = 8'd200;
    b = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_div_zero", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    run_op("d50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

    // sampled sweep against an arithmetic model, including zero divisors
    for (int i = 0; i < 120; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (rb == 8'd0) begin
        eq = 8'd255;
        er = ra;
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      run_op("sweep", ra, rb, eq, er, rb == 8'd0);
      if (rb != 8'd0) begin
        chk("sweep_identity", 32'(q) * 32'(rb) + 32'(r), 32'(ra));
        chk("sweep_r_lt_b", {31'd0, r < rb}, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
